// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Sits behind the calculator ALU. It turns the unsigned magnitude and sign
// into three BCD digits and leading-zero blank flags for the display driver.
module result_bcd_converter #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  input  logic            neg_in,
  output logic            busy,
  output logic            done,
  output logic            valid,
  output logic [3:0]      hundreds,
  output logic [3:0]      tens,
  output logic [3:0]      ones,
  output logic            neg_out,
  output logic            hundreds_blank,
  output logic            tens_blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [IN_W-1:0]    shreg;
  logic [BCD_W-1:0]   bcd;
  logic [CNT_W-1:0]   cnt;
  logic               sign;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [IN_W-1:0]    shreg_next;

  // Add 3 to every nibble that is 5 or more, so that the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // One double-dabble iteration: correct first, then shift {bcd, shreg} left.
  always_comb begin
    bcd_adj    = add3(bcd);
    bcd_next   = {bcd_adj[BCD_W-2:0], shreg[IN_W-1]};
    shreg_next = {shreg[IN_W-2:0], 1'b0};
  end

  // Control FSM, conversion datapath and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shreg          <= '0;
      bcd            <= '0;
      cnt            <= '0;
      sign           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      valid          <= 1'b0;
      hundreds       <= 4'd0;
      tens           <= 4'd0;
      ones           <= 4'd0;
      neg_out        <= 1'b0;
      hundreds_blank <= 1'b1;
      tens_blank     <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE lasts one cycle; start here gives a back-to-back conversion.
          done <= 1'b0;
          if (start) begin
            shreg <= bin;
            sign  <= neg_in;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // start, bin and neg_in are deliberately ignored while shifting.
          shreg <= shreg_next;
          bcd   <= bcd_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            // Final iteration: publish the result computed this cycle.
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            valid          <= 1'b1;
            hundreds       <= bcd_next[11:8];
            tens           <= bcd_next[7:4];
            ones           <= bcd_next[3:0];
            neg_out        <= sign && (bcd_next != '0);
            hundreds_blank <= (bcd_next[11:8] == 4'd0);
            tens_blank     <= (bcd_next[11:4] == 8'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: directed scenarios plus randomized
// conversions, checked against an arithmetic decimal model.
module tb_result_bcd_converter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] bin;
  logic       neg_in;
  logic       busy, done, valid;
  logic [3:0] hundreds, tens, ones;
  logic       neg_out, hundreds_blank, tens_blank;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  result_bcd_converter #(.IN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .neg_in(neg_in),
    .busy(busy), .done(done), .valid(valid),
    .hundreds(hundreds), .tens(tens), .ones(ones), .neg_out(neg_out),
    .hundreds_blank(hundreds_blank), .tens_blank(tens_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hundreds, tens, ones, neg_out, hundreds_blank, tens_blank}.
  function automatic logic [14:0] model(input int v, input bit n);
    int h, t, o;
    logic [3:0] hh, tt, oo;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    hh = 4'(h); tt = 4'(t); oo = 4'(o);
    return {hh, tt, oo, (n && v != 0), (h == 0), (h == 0 && t == 0)};
  endfunction

  function automatic logic [14:0] observed();
    return {hundreds, tens, ones, neg_out, hundreds_blank, tens_blank};
  endfunction

  // Pulse start for one cycle and wait (bounded) for done. lat counts cycles
  // from the accepting cycle to the done cycle; bcnt counts busy cycles.
  task automatic run_conv(input int v, input bit n, output int lat,
                          output int bcnt, output bit timed_out);
    @(negedge clk);
    bin = 8'(v); neg_in = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0; timed_out = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bin = 8'd0; neg_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy, done, valid} !== 3'b000)
      $display("FAIL reset_ctrl got=%b exp=000", {busy, done, valid});
    else pass_cnt++;
    chk_cnt++;
    if (observed() !== 15'b0000_0000_0000_0_1_1)
      $display("FAIL reset_out got=%h exp=%h", observed(), 15'b0000_0000_0000_0_1_1);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input int v, input bit n, input string nm);
    int lat, bcnt; bit to;
    run_conv(v, n, lat, bcnt, to);
    chk_cnt++;
    if (to || lat != 9) $display("FAIL %s_latency got=%0d exp=9 timeout=%0d", nm, lat, to);
    else pass_cnt++;
    chk_cnt++;
    if (bcnt != 8) $display("FAIL %s_busy_cycles got=%0d exp=8", nm, bcnt);
    else pass_cnt++;
    chk_cnt++;
    if (observed() !== model(v, n))
      $display("FAIL %s_out got=%h exp=%h", nm, observed(), model(v, n));
    else pass_cnt++;
    chk_cnt++;
    if ({valid, busy} !== 2'b10) $display("FAIL %s_valid_busy got=%b exp=10", nm, {valid, busy});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || observed() !== model(v, n))
      $display("FAIL %s_hold got=%b/%h exp=0/%h", nm, done, observed(), model(v, n));
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int dones = 0, first_cyc = -1;
    logic [14:0] first_out = '0;
    @(negedge clk);
    bin = 8'd255; neg_in = 1'b0; start = 1'b1;
    @(negedge clk);                   // cycle N+1
    start = 1'b0;
    @(negedge clk);                   // N+2
    @(negedge clk);                   // N+3
    bin = 8'd10; neg_in = 1'b1; start = 1'b1;
    for (int c = 3; c < 30; c++) begin
      if (done) begin
        dones++;
        if (first_cyc < 0) begin first_cyc = c; first_out = observed(); end
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk_cnt++;
    if (dones != 1) $display("FAIL ignored_done_count got=%0d exp=1", dones);
    else pass_cnt++;
    chk_cnt++;
    if (first_cyc != 9) $display("FAIL ignored_latency got=%0d exp=9", first_cyc);
    else pass_cnt++;
    chk_cnt++;
    if (first_out !== model(255, 0))
      $display("FAIL ignored_out got=%h exp=%h", first_out, model(255, 0));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit to;
    int gap = 0;
    bit seen = 1'b0;
    run_conv(99, 0, lat, bcnt, to);
    chk_cnt++;
    if (to || observed() !== model(99, 0))
      $display("FAIL b2b_first got=%h exp=%h", observed(), model(99, 0));
    else pass_cnt++;
    bin = 8'd100; neg_in = 1'b1; start = 1'b1;  // during the DONE cycle
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", busy);
    else pass_cnt++;
    for (int k = 1; k < 30; k++) begin
      if (done) begin gap = k; seen = 1'b1; break; end
      @(negedge clk);
    end
    chk_cnt++;
    if (!seen || gap != 9) $display("FAIL b2b_gap got=%0d exp=9", gap);
    else pass_cnt++;
    chk_cnt++;
    if (observed() !== model(100, 1))
      $display("FAIL b2b_second got=%h exp=%h", observed(), model(100, 1));
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(negedge clk);
    bin = 8'd150; neg_in = 1'b0; start = 1'b1;
    @(negedge clk);                   // N+1
    start = 1'b0;
    repeat (3) @(negedge clk);        // N+4
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy, done, valid} !== 3'b000 || observed() !== 15'b0000_0000_0000_0_1_1)
      $display("FAIL abort_immediate got=%b/%h exp=000/%h", {busy, done, valid},
               observed(), 15'b0000_0000_0000_0_1_1);
    else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done) dones++;
    end
    chk_cnt++;
    if (dones != 0) $display("FAIL abort_no_done got=%0d exp=0", dones);
    else pass_cnt++;
    test_basic(42, 0, "after_abort");
  endtask

  task automatic test_random();
    int lat, bcnt; bit to;
    int v; bit n;
    for (int i = 0; i < 25; i++) begin
      v = int'($urandom_range(0, 255));
      n = 1'($urandom_range(0, 1));
      run_conv(v, n, lat, bcnt, to);
      chk_cnt++;
      if (to || lat != 9 || observed() !== model(v, n))
        $display("FAIL rand_%0d v=%0d n=%0d got=%h lat=%0d exp=%h lat=9",
                 i, v, n, observed(), lat, model(v, n));
      else pass_cnt++;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic(225, 0, "v225");
    test_basic(7, 1, "v7neg");
    test_basic(0, 1, "v0neg");
    test_basic(255, 1, "v255neg");
    test_basic(10, 0, "v10");
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
